cache_tag_lookup: RTL and testbench
===================================

# cache_tag_lookup

- Tag/valid lookup and miss-allocation stage for the 4-way set-associative cache; sits directly upstream of the per-set tree-PLRU block and drives its access/victim ports.
- Accepts one lookup at a time and compares the tag against the 4 ways of the indexed set.
- On a hit, reports the way and updates PLRU. On a miss, picks a victim way, issues a refill request, installs the new tag on refill completion, and reports the miss.

## Interface
- SETS, 16, number of sets (power of 2, ≥2); SET_W = $clog2(SETS)
- TAG_W, 20, tag width in bits
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  lookup request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_tag  in  TAG_W  lookup tag
- req_set  in  SET_W  lookup set index
- rsp_valid  out  1  one-cycle response pulse
- rsp_hit  out  1  1 = hit, 0 = miss (line now filled)
- rsp_way  out  2  hit way or allocated way
- lru_set  out  SET_W  set index presented to PLRU
- lru_acc_valid  out  1  PLRU access-update strobe
- lru_acc_way  out  2  way accessed
- lru_vic_req  out  1  PLRU victim request (PLRU self-updates on it)
- lru_vic_way  in  2  PLRU victim, combinational in same cycle as lru_vic_req
- fill_req_valid  out  1  refill request
- fill_req_ready  in  1  refill request accepted
- fill_req_tag  out  TAG_W  refill tag
- fill_req_set  out  SET_W  refill set
- fill_req_way  out  2  way being filled
- fill_done  in  1  one-cycle refill-complete pulse

## Operation
- Storage: tag[SETS][4] and valid[SETS][4], both in flops.
- FSM states: IDLE, LOOKUP, ALLOC, FILL_REQ, FILL_WAIT, RESP (plus FLUSH, see Configuration).
- IDLE:
  - req_ready = 1.
  - On handshake, register tag and set; go to LOOKUP.
- LOOKUP:
  - Compare the registered tag against the valid ways.
  - Hit (any valid way matches): pulse lru_acc_valid with lru_acc_way = hit way; go to RESP with rsp_hit = 1.
  - Multiple matches: the lowest index wins.
  - Miss: go to ALLOC.
- ALLOC:
  - If any way in the set is invalid: select the lowest-index invalid way and pulse lru_acc_valid with that way; do not assert lru_vic_req.
  - If all 4 ways are valid: assert lru_vic_req for exactly this one cycle, capture lru_vic_way, and do not assert lru_acc_valid (the PLRU updates on its victim request; a second update is forbidden).
  - Clear valid[set][victim]; go to FILL_REQ.
- FILL_REQ:
  - Hold fill_req_valid and the fill_req_* fields stable until fill_req_ready; then go to FILL_WAIT.
- FILL_WAIT:
  - On fill_done: write tag[set][way] = registered tag and set valid = 1; go to RESP with rsp_hit = 0 and rsp_way = allocated way.
- RESP:
  - rsp_valid = 1 for one cycle; return to IDLE.
- lru_set is driven with the registered set in LOOKUP and ALLOC, and 0 elsewhere.
- Ignored inputs:
  - fill_done outside FILL_WAIT, including the fill_req handshake cycle.
  - req_valid outside IDLE.

## Timing
- Reset values:
  - state = IDLE; all valid bits = 0; tags are don't-care.
  - req_ready = 1; every other output = 0.
- Hit latency: handshake at edge 0; LOOKUP in cycle 1 (with lru_acc_valid); rsp_valid in cycle 2. Next handshake is possible in cycle 3.
- Miss latency: handshake at edge 0; LOOKUP cycle 1; ALLOC cycle 2; fill_req_valid from cycle 3.
  - rsp_valid is asserted the cycle after fill_done is sampled in FILL_WAIT.
- Back-to-back request to the set just filled: hits, because the tag/valid write on fill_done precedes the next LOOKUP.
- Reset mid-operation: the FSM aborts to IDLE, all valid bits clear, and fill_req_valid drops immediately. A late fill_done is ignored.

## Configuration
- TAG_FLUSH_EN defined: adds flush_req (in, 1) and flush_busy (out, 1).
  - In IDLE, flush_req takes priority over req_valid and enters FLUSH.
  - FLUSH clears valid[s][0..3] for s = 0..SETS-1, one set per cycle, taking exactly SETS cycles.
  - During FLUSH, req_ready = 0 and flush_busy = 1; the FSM then returns to IDLE.
- Not defined: the ports and FLUSH state are absent; valid bits are cleared only by reset.

## Structure
- Package cache_pkg holds:
  - way_t (logic [1:0]) and localparam WAYS = 4.
  - The lookup state enum typedef.
  - TAG_W/SETS defaults as localparams.
- One combinational sub-module, tag_match4: inputs are 4 tags, 4 valid bits and the lookup tag; outputs are hit, hit_way, has_invalid and first_invalid_way.

## Test plan
- After reset, lookup set 3, tag 0x00ABC: miss; ALLOC selects way 0, no lru_vic_req; fill_req = {0x00ABC, 3, 0}. After fill_done, rsp_hit = 0 and rsp_way = 0. Repeating the lookup gives rsp_hit = 1, rsp_way = 0, 2 cycles after handshake, with lru_acc_way = 0.
- Fill set 5 with tags 1, 2, 3, 4 (ways 0–3), then look up tag 5 with lru_vic_way = 2: exactly one lru_vic_req cycle, no lru_acc_valid, fill_req_way = 2. Afterwards tag 3 misses and tag 5 hits way 2.
- Hold fill_req_ready = 0 for 10 cycles: fill_req_valid and its fields stay stable and req_ready = 0. A fill_done pulsed during FILL_REQ is ignored.
- Assert rst_n = 0 during FILL_WAIT: all outputs return to reset values and a prior hit line now misses. A late fill_done produces no rsp_valid.
- With TAG_FLUSH_EN, SETS = 16: flush_req in IDLE gives flush_busy for 16 cycles with req_ready = 0; afterwards all previously filled lines miss.

Source files
------------

// File: rtl/cache_tag_lookup_pkg.sv
// Shared types for the cache tag lookup stage: way index, state encoding, default geometry.
// TAG_FLUSH_EN adds the FLUSH state to the encoding.
package cache_pkg;
   localparam int WAYS      = 4;
   localparam int DEF_SETS  = 16;
   localparam int DEF_TAG_W = 20;

   typedef logic [1:0] way_t;

   typedef enum logic [2:0] {
      LK_IDLE,
      LK_LOOKUP,
      LK_ALLOC,
      LK_FILL_REQ,
      LK_FILL_WAIT,
      LK_RESP
`ifdef TAG_FLUSH_EN
      , LK_FLUSH
`endif
   } lk_state_t;
endpackage

// File: rtl/cache_tag_lookup_tag_match4.sv
// Combinational 4-way tag compare plus first-invalid-way search for one set.
module tag_match4
   import cache_pkg::*;
#(
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic [WAYS-1:0][TAG_W-1:0] tags,
   input  logic [WAYS-1:0]            valid,
   input  logic [TAG_W-1:0]           tag,
   output logic                       hit,
   output way_t                       hit_way,
   output logic                       has_invalid,
   output way_t                       first_invalid_way
);

   // Walk from the top way down so the lowest index is written last and wins.
   always_comb begin
      hit               = 1'b0;
      hit_way           = '0;
      has_invalid       = 1'b0;
      first_invalid_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[w] && (tags[w] == tag)) begin
            hit     = 1'b1;
            hit_way = way_t'(w);
         end
         if (!valid[w]) begin
            has_invalid       = 1'b1;
            first_invalid_way = way_t'(w);
         end
      end
   end

endmodule

// File: rtl/cache_tag_lookup.sv
// Tag/valid lookup and miss allocation for a 4-way set-associative cache, driving the PLRU.
// TAG_FLUSH_EN adds flush_req/flush_busy and a one-set-per-cycle invalidate sweep.
module cache_tag_lookup
   import cache_pkg::*;
#(
   parameter  int SETS  = DEF_SETS,
   parameter  int TAG_W = DEF_TAG_W,
   localparam int SET_W = $clog2(SETS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [SET_W-1:0] req_set,
   output logic             rsp_valid,
   output logic             rsp_hit,
   output way_t             rsp_way,
   output logic [SET_W-1:0] lru_set,
   output logic             lru_acc_valid,
   output way_t             lru_acc_way,
   output logic             lru_vic_req,
   input  way_t             lru_vic_way,
   output logic             fill_req_valid,
   input  logic             fill_req_ready,
   output logic [TAG_W-1:0] fill_req_tag,
   output logic [SET_W-1:0] fill_req_set,
   output way_t             fill_req_way,
`ifdef TAG_FLUSH_EN
   input  logic             flush_req,
   output logic             flush_busy,
`endif
   input  logic             fill_done
);

   lk_state_t                          state_q, state_d;
   logic [TAG_W-1:0]                   tag_q, tag_d;
   logic [SET_W-1:0]                   set_q, set_d;
   way_t                               way_q, way_d;
   logic                               hit_q, hit_d;
   logic [SETS-1:0][WAYS-1:0]          valid_q, valid_d;
   logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tags_q, tags_d;
`ifdef TAG_FLUSH_EN
   logic [SET_W-1:0]                   flush_cnt_q, flush_cnt_d;
`endif

   logic m_hit, m_has_inv;
   way_t m_hit_way, m_inv_way;

   tag_match4 #(.TAG_W(TAG_W)) u_match (
      .tags              (tags_q[set_q]),
      .valid             (valid_q[set_q]),
      .tag               (tag_q),
      .hit               (m_hit),
      .hit_way           (m_hit_way),
      .has_invalid       (m_has_inv),
      .first_invalid_way (m_inv_way)
   );

   always_comb begin
      state_d        = state_q;
      tag_d          = tag_q;
      set_d          = set_q;
      way_d          = way_q;
      hit_d          = hit_q;
      valid_d        = valid_q;
      tags_d         = tags_q;
      req_ready      = 1'b0;
      rsp_valid      = 1'b0;
      rsp_hit        = 1'b0;
      rsp_way        = '0;
      lru_set        = '0;
      lru_acc_valid  = 1'b0;
      lru_acc_way    = '0;
      lru_vic_req    = 1'b0;
      fill_req_valid = 1'b0;
      fill_req_tag   = '0;
      fill_req_set   = '0;
      fill_req_way   = '0;
`ifdef TAG_FLUSH_EN
      flush_busy     = 1'b0;
      flush_cnt_d    = flush_cnt_q;
`endif
      case (state_q)
         LK_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               tag_d   = req_tag;
               set_d   = req_set;
               state_d = LK_LOOKUP;
            end
`ifdef TAG_FLUSH_EN
            if (flush_req) begin
               req_ready   = 1'b0;
               flush_cnt_d = '0;
               state_d     = LK_FLUSH;
            end
`endif
         end
         LK_LOOKUP: begin
            lru_set = set_q;
            if (m_hit) begin
               lru_acc_valid = 1'b1;
               lru_acc_way   = m_hit_way;
               way_d         = m_hit_way;
               hit_d         = 1'b1;
               state_d       = LK_RESP;
            end else begin
               state_d = LK_ALLOC;
            end
         end
         LK_ALLOC: begin
            // The PLRU updates itself on a victim request, so no access strobe then.
            lru_set = set_q;
            hit_d   = 1'b0;
            if (m_has_inv) begin
               lru_acc_valid = 1'b1;
               lru_acc_way   = m_inv_way;
               way_d         = m_inv_way;
            end else begin
               lru_vic_req = 1'b1;
               way_d       = lru_vic_way;
            end
            valid_d[set_q][way_d] = 1'b0;
            state_d = LK_FILL_REQ;
         end
         LK_FILL_REQ: begin
            fill_req_valid = 1'b1;
            fill_req_tag   = tag_q;
            fill_req_set   = set_q;
            fill_req_way   = way_q;
            if (fill_req_ready) state_d = LK_FILL_WAIT;
         end
         LK_FILL_WAIT: begin
            if (fill_done) begin
               tags_d[set_q][way_q]  = tag_q;
               valid_d[set_q][way_q] = 1'b1;
               state_d               = LK_RESP;
            end
         end
         LK_RESP: begin
            rsp_valid = 1'b1;
            rsp_hit   = hit_q;
            rsp_way   = way_q;
            state_d   = LK_IDLE;
         end
`ifdef TAG_FLUSH_EN
         LK_FLUSH: begin
            flush_busy           = 1'b1;
            valid_d[flush_cnt_q] = '0;
            flush_cnt_d          = flush_cnt_q + 1'b1;
            if (flush_cnt_q == SET_W'(SETS - 1)) state_d = LK_IDLE;
         end
`endif
         default: state_d = LK_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LK_IDLE;
         tag_q       <= '0;
         set_q       <= '0;
         way_q       <= '0;
         hit_q       <= 1'b0;
         valid_q     <= '0;
`ifdef TAG_FLUSH_EN
         flush_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         set_q       <= set_d;
         way_q       <= way_d;
         hit_q       <= hit_d;
         valid_q     <= valid_d;
`ifdef TAG_FLUSH_EN
         flush_cnt_q <= flush_cnt_d;
`endif
      end
   end

   // Tag contents are qualified by valid bits, so they need no reset.
   always_ff @(posedge clk) begin
      tags_q <= tags_d;
   end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Randomized bench for cache_tag_lookup against an array-based model of the tag store.
module tb_cache_tag_lookup;
   import cache_pkg::*;

   localparam int SETS  = 16;
   localparam int TAG_W = 20;
   localparam int SET_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [TAG_W-1:0] req_tag = '0;
   logic [SET_W-1:0] req_set = '0;
   logic             rsp_valid, rsp_hit;
   way_t             rsp_way;
   logic [SET_W-1:0] lru_set;
   logic             lru_acc_valid, lru_vic_req;
   way_t             lru_acc_way;
   way_t             lru_vic_way = '0;
   logic             fill_req_valid;
   logic             fill_req_ready = 1'b0;
   logic [TAG_W-1:0] fill_req_tag;
   logic [SET_W-1:0] fill_req_set;
   way_t             fill_req_way;
   logic             fill_done = 1'b0;
`ifdef TAG_FLUSH_EN
   logic             flush_req = 1'b0;
   logic             flush_busy;
`endif

   cache_tag_lookup #(.SETS(SETS), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_set(req_set),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
      .lru_set(lru_set), .lru_acc_valid(lru_acc_valid), .lru_acc_way(lru_acc_way),
      .lru_vic_req(lru_vic_req), .lru_vic_way(lru_vic_way),
      .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
      .fill_req_tag(fill_req_tag), .fill_req_set(fill_req_set), .fill_req_way(fill_req_way),
`ifdef TAG_FLUSH_EN
      .flush_req(flush_req), .flush_busy(flush_busy),
`endif
      .fill_done(fill_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference tag store: which (set, way) slots hold which tag.
   bit               mv[SETS][4];
   logic [TAG_W-1:0] mt[SETS][4];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < 4; w++) mv[s][w] = 0;
   endtask

   task automatic chk_rst(input string p);
      chk({p, "_req_ready"}, req_ready, 1);
      chk({p, "_rsp_valid"}, rsp_valid, 0);
      chk({p, "_rsp_hit"}, rsp_hit, 0);
      chk({p, "_rsp_way"}, rsp_way, 0);
      chk({p, "_lru_set"}, lru_set, 0);
      chk({p, "_acc_valid"}, lru_acc_valid, 0);
      chk({p, "_acc_way"}, lru_acc_way, 0);
      chk({p, "_vic_req"}, lru_vic_req, 0);
      chk({p, "_fill_valid"}, fill_req_valid, 0);
      chk({p, "_fill_tag"}, fill_req_tag, 0);
      chk({p, "_fill_set"}, fill_req_set, 0);
      chk({p, "_fill_way"}, fill_req_way, 0);
`ifdef TAG_FLUSH_EN
      chk({p, "_flush_busy"}, flush_busy, 0);
`endif
   endtask

   // One complete lookup. rw = cycles fill_req_ready is held low, dw = cycles before
   // fill_done (>=1), spur = pulse a fill_done the DUT must ignore during FILL_REQ.
   task automatic lookup(input logic [TAG_W-1:0] tg, input int s, input way_t vic,
                         input int rw, input int dw, input bit spur);
      bit   eh, full;
      way_t ew;
      eh = 0; full = 1; ew = '0;
      for (int w = 0; w < 4; w++)
         if (!eh && mv[s][w] && mt[s][w] == tg) begin eh = 1; ew = way_t'(w); end
      if (!eh) begin
         for (int w = 0; w < 4; w++)
            if (full && !mv[s][w]) begin full = 0; ew = way_t'(w); end
         if (full) ew = vic;
      end

      req_valid = 1; req_tag = tg; req_set = SET_W'(s); lru_vic_way = vic;
      #1;
      chk("idle_req_ready", req_ready, 1);
      tick;
      req_valid = 0; req_tag = TAG_W'($urandom);
      #1;
      chk("lk_lru_set", lru_set, s);
      chk("lk_acc_valid", lru_acc_valid, eh);
      if (eh) chk("lk_acc_way", lru_acc_way, ew);
      chk("lk_vic_req", lru_vic_req, 0);
      chk("lk_rsp_valid", rsp_valid, 0);
      chk("lk_req_ready", req_ready, 0);
      if (!eh) begin
         tick;
         chk("al_lru_set", lru_set, s);
         chk("al_acc_valid", lru_acc_valid, !full);
         chk("al_vic_req", lru_vic_req, full);
         if (!full) chk("al_acc_way", lru_acc_way, ew);
         mv[s][ew] = 0;
         tick;
         for (int i = 0; i < rw; i++) begin
            fill_done = spur && (i == 0);
            #1;
            chk("fr_valid", fill_req_valid, 1);
            chk("fr_tag", fill_req_tag, tg);
            chk("fr_set", fill_req_set, s);
            chk("fr_way", fill_req_way, ew);
            chk("fr_req_ready", req_ready, 0);
            tick;
            fill_done = 0;
         end
         fill_req_ready = 1; fill_done = spur;
         #1;
         chk("fr_hs_valid", fill_req_valid, 1);
         chk("fr_hs_tag", fill_req_tag, tg);
         chk("fr_hs_way", fill_req_way, ew);
         tick;
         fill_req_ready = 0; fill_done = 0;
         #1;
         for (int i = 0; i < dw; i++) begin
            chk("fw_rsp_valid", rsp_valid, 0);
            chk("fw_fill_valid", fill_req_valid, 0);
            tick;
         end
         fill_done = 1;
         tick;
         fill_done = 0;
         mt[s][ew] = tg; mv[s][ew] = 1;
      end else begin
         tick;
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_hit", rsp_hit, eh);
      chk("rsp_way", rsp_way, ew);
      tick;
      chk("rsp_pulse_end", rsp_valid, 0);
   endtask

   initial begin
      model_clear();
      #3;
      chk_rst("in_rst");
      @(posedge clk); #1;
      rst_n = 1;
      #1;
      chk_rst("post_rst");

      // First miss into an empty set, then the same line hits.
      lookup(20'h00ABC, 3, 2'd3, 1, 1, 0);
      lookup(20'h00ABC, 3, 2'd3, 0, 1, 0);

      // Fill set 5 ways 0..3, then force a PLRU victim.
      for (int t = 1; t <= 4; t++) lookup(TAG_W'(t), 5, 2'd1, 0, 1, 0);
      lookup(20'd5, 5, 2'd2, 0, 2, 0);
      lookup(20'd5, 5, 2'd0, 0, 1, 0);
      lookup(20'd3, 5, 2'd1, 0, 1, 0);

      // Long refill back-pressure with a stray fill_done.
      lookup(20'h12345, 7, 2'd0, 10, 2, 1);

      // Random traffic over a few sets and a small tag space for hits and evictions.
      for (int n = 0; n < 150; n++)
         lookup(TAG_W'($urandom_range(1, 6)), $urandom_range(0, 3) * 5,
                way_t'($urandom_range(0, 3)), $urandom_range(0, 2),
                $urandom_range(1, 3), 1'($urandom_range(0, 1)));

`ifdef TAG_FLUSH_EN
      flush_req = 1;
      #1;
      chk("fl_req_ready_idle", req_ready, 0);
      tick;
      flush_req = 0;
      for (int i = 0; i < SETS; i++) begin
         chk("fl_busy", flush_busy, 1);
         chk("fl_req_ready", req_ready, 0);
         tick;
      end
      chk("fl_done_busy", flush_busy, 0);
      chk("fl_done_ready", req_ready, 1);
      model_clear();
      lookup(20'h00ABC, 3, 2'd0, 0, 1, 0);
      lookup(20'd5, 5, 2'd0, 0, 1, 0);
`endif

      // Reset while waiting for a refill.
      req_valid = 1; req_tag = 20'hFFFFF; req_set = 4'd9;
      tick;
      req_valid = 0;
      tick;
      tick;
      fill_req_ready = 1;
      tick;
      fill_req_ready = 0;
      #2;
      rst_n = 0;
      #1;
      chk_rst("mid_rst");
      model_clear();
      @(posedge clk); #1;
      rst_n = 1;
      fill_done = 1;
      tick;
      fill_done = 0;
      for (int i = 0; i < 3; i++) begin
         chk("late_done_rsp", rsp_valid, 0);
         chk("late_done_fill", fill_req_valid, 0);
         tick;
      end
      lookup(20'h00ABC, 3, 2'd0, 0, 1, 0);
      lookup(20'h00ABC, 3, 2'd0, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
